n_bit_fifo: RTL
===============

// Module: n_bit_fifo
// PURPOSE
//   Parametrised synchronous FIFO: next generation of the team's n-bit enable register.
//   Buffers WIDTH-bit words (coin codes, vend requests) between the soda-machine input
//   decoder and the vend controller so bursts of coin events are not lost.
//   Adds depth, occupancy count, threshold flag and sticky error flags over a plain register.
// PARAMETERS
//   WIDTH     8  data word width in bits, >= 1
//   DEPTH     4  number of storage entries, >= 2; need not be a power of two
//   AF_LEVEL  3  almost_full asserts when count >= AF_LEVEL, 1..DEPTH
// PORTS
//   clk        in   1               clock, all state updates on rising edge
//   nrst       in   1               reset, asynchronous, active-low
//   clr        in   1               synchronous flush, active-high
//   push       in   1               write request; wr_data sampled on this edge
//   wr_data    in   WIDTH           data to write
//   pop        in   1               read request
//   rd_data    out  WIDTH           registered read data; valid when rd_valid=1
//   rd_valid   out  1               one-cycle pulse: rd_data updated by the previous pop
//   full       out  1               count == DEPTH
//   empty      out  1               count == 0
//   almost_full out 1               count >= AF_LEVEL
//   count      out  CW              occupancy, CW = clog2(DEPTH+1)
//   overflow   out  1               sticky: push refused while full
//   underflow  out  1               sticky: pop refused while empty
// BEHAVIOUR
//   - Reset (nrst=0, async): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//     overflow=underflow=0; so empty=1, full=0, almost_full=0. Memory contents not reset.
//   - clr=1 at an edge: same values as reset, overrides push/pop in that cycle.
//   - Accepted push: mem[wr_ptr]<=wr_data; wr_ptr wraps DEPTH-1 -> 0 (explicit compare).
//   - Accepted pop: rd_data<=mem[rd_ptr]; rd_ptr wraps DEPTH-1 -> 0; rd_valid=1 next cycle.
//     Read latency: 1 clock from pop edge to rd_data/rd_valid. rd_data holds until next pop.
//   - push accepted iff !full OR (full AND pop accepted same cycle).
//   - pop accepted iff !empty. Push to empty plus pop same cycle: pop refused, underflow set,
//     push accepted (no fall-through).
//   - count: +1 push-only, -1 pop-only, unchanged both/neither. Flags are decoded from
//     registered count (no extra latency); count never exceeds DEPTH, never below 0.
//   - Refused push: data dropped, overflow<=1. Refused pop: rd_valid=0, underflow<=1.
//     Sticky flags clear only on nrst or clr.
//   - Reset asserted mid-operation: all state cleared immediately; stored words are lost.
//   - No state machine: control is pointer/count arithmetic; all outputs registered or
//     decoded from registered count.
// STRUCTURE
//   - Shared package soda_pkg: clog2 constant function, FIFO_DEF_WIDTH/FIFO_DEF_DEPTH.
//   - One sub-module: fifo_mem (DEPTH x WIDTH array, sync write, sync registered read,
//     no reset on array). Pointer, count and flag logic stays in n_bit_fifo.
// TESTING (WIDTH=8, DEPTH=4, AF_LEVEL=3)
//   1. Reset: drive nrst=0 mid-cycle -> immediately count=0, empty=1, rd_valid=0, flags 0.
//   2. Push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at 3, full at 4; then pop x4 ->
//      rd_data 0x11,0x22,0x33,0x44 each with rd_valid one cycle after pop; empty=1.
//   3. Full, push 0x55 alone -> dropped, overflow=1, count=4; next pop returns 0x11.
//   4. Full, push 0x66 + pop same cycle -> rd_data=0x11, count stays 4; drain gives
//      0x22,0x33,0x44,0x66 (wrap-around of both pointers checked).
//   5. Empty, push 0x77 + pop same cycle -> underflow=1, rd_valid=0, count=1; next pop -> 0x77.
//   6. Count=2 with overflow=1, assert clr one cycle -> count=0, empty=1, overflow=0,
//      rd_data=0; subsequent push 0x99/pop returns 0x99.

Source files
------------

// File: rtl/soda_pkg.sv
// Shared soda-machine package: sizing helper and default FIFO geometry.
package soda_pkg;

    localparam int unsigned FIFO_DEF_WIDTH = 8;
    localparam int unsigned FIFO_DEF_DEPTH = 4;

    // Ceiling log2; returns 0 for an argument of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array with synchronous write and registered read port.
module fifo_mem
    import soda_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEF_DEPTH,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array write; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value until the next accepted read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/n_bit_fifo.sv
// Synchronous FIFO between the coin/vend input decoder and the vend controller.
module n_bit_fifo
    import soda_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = 3,
    localparam int unsigned CW      = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Status flags decoded straight from the registered occupancy.
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AF_LEVEL));

    // Accept logic: a full FIFO takes a push only when a pop frees a slot the same edge.
    always_comb begin
        pop_ok  = 1'b0;
        push_ok = 1'b0;
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    // Pointers, occupancy, read-valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            rd_valid <= pop_ok;
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (clr),
        .we      (push_ok && !clr),
        .waddr   (wr_ptr),
        .wdata   (wr_data),
        .re      (pop_ok && !clr),
        .raddr   (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
